// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the stage/CP0 side and pipe_ctrl.
// Latency: none, wires only.
// Backpressure: none; the stall vector is the flow control it carries.
interface pipe_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    // Requests and exception reports towards the controller
    logic [3:0]             stall_req;
    logic                   ibus_busy;
    logic                   exc_valid;
    logic [5:0]             exc_type;
    logic                   exc_eret;
    logic [31:0]            cp0_epc;

    // Controller responses
    logic [3:0]             stall;
    logic                   exception;
    logic [31:0]            new_pc;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [7:0]             exc_cnt;
    logic [5:0]             exc_code;   // last accepted exc_type, debug only

    modport master (
        output stall_req, ibus_busy, exc_valid, exc_type, exc_eret, cp0_epc,
        input  stall, exception, new_pc, busy, stall_cnt, exc_cnt, exc_code
    );

    modport slave (
        input  stall_req, ibus_busy, exc_valid, exc_type, exc_eret, cp0_epc,
        output stall, exception, new_pc, busy, stall_cnt, exc_cnt, exc_code
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Merges stage stall requests and sequences exception/ERET redirects (drain ibus, then 1-cycle flush).
// Latency: stall is combinational; flush pulse 1 cycle after acceptance, or 1 cycle after ibus is seen idle.
// Backpressure: holds every stage (stall=4'hF) while an accepted redirect waits for the ibus to drain.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          STALL_CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             w_stall;
    logic                   w_accept;
    logic [31:0]            w_target;

    logic [31:0]            r_target;
    logic [5:0]             r_exc_code;
    logic                   r_exception;
    logic [31:0]            r_new_pc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [7:0]             r_exc_cnt;

    // ERET redirects to EPC; every other exception goes to the fixed vector
    assign w_target = bus.exc_eret ? bus.cp0_epc : EXC_VECTOR;

    // Next-state and stall vector; only RUN can accept an event, so the first one wins
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 4'b0000;
        w_accept    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.exc_valid) begin
                    // exception overrides any stall request this cycle
                    w_accept    = 1'b1;
                    w_state_nxt = bus.ibus_busy ? ST_DRAIN : ST_REDIRECT;
                end else begin
                    w_stall = bus.stall_req;
                end
            end
            ST_DRAIN: begin
                w_stall = 4'b1111;
                if (!bus.ibus_busy) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // flush is on the wire now; anything reported this cycle is being killed
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State register; reset aborts any pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture redirect target and exception code at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target   <= 32'h0;
            r_exc_code <= 6'h0;
        end else if (w_accept) begin
            r_target   <= w_target;
            r_exc_code <= bus.exc_type;
        end
    end

    // Registered flush pulse and redirect PC, live only for the REDIRECT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exception <= 1'b0;
            r_new_pc    <= 32'h0;
        end else if (w_state_nxt == ST_REDIRECT) begin
            r_exception <= 1'b1;
            // on the idle-bus path the target is not in r_target yet
            r_new_pc    <= (r_state == ST_RUN) ? w_target : r_target;
        end else begin
            r_exception <= 1'b0;
            r_new_pc    <= 32'h0;
        end
    end

    // Stall-cycle counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall != 4'b0000) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    // Accepted-event counter, saturating at 8'hFF
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_cnt <= 8'h0;
        end else if (w_accept && (r_exc_cnt != 8'hFF)) begin
            r_exc_cnt <= r_exc_cnt + 8'd1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.exception = r_exception;
    assign bus.new_pc    = r_new_pc;
    assign bus.busy      = (r_state != ST_RUN);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.exc_cnt   = r_exc_cnt;
    assign bus.exc_code  = r_exc_code;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a cycle-time reference model.
// Latency: model predicts flush at acceptance+1, or at (first idle-ibus cycle after acceptance)+1.
// Backpressure: checks stall=4'hF for every cycle a redirect is pending.
module tb_pipe_ctrl;

    localparam int          CW  = 8;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STALL_CNT_W(CW)) ifc ();

    pipe_ctrl #(
        .EXC_VECTOR  (VEC),
        .STALL_CNT_W (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  code;
    } flush_t;

    flush_t sb_q[$];
    flush_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    // Reference model: an event is open from acceptance until its flush cycle
    bit          m_open    = 1'b0;
    int          m_flush   = -1;
    logic [CW-1:0] m_scnt  = '0;
    int          m_accepts = 0;

    logic [3:0]    exp_stall = 4'h0;
    bit            exp_busy  = 1'b0;
    bit            exp_exc   = 1'b0;
    logic [CW-1:0] exp_scnt  = '0;
    logic [7:0]    exp_ecnt  = 8'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model
    task automatic cycle(input bit r, input logic [3:0] sreq, input bit ib, input bit v,
                         input logic [5:0] t, input bit er, input logic [31:0] epc);
        flush_t f;
        bit     accept;
        @(posedge clk);
        #1;
        rst           = r;
        ifc.stall_req = sreq;
        ifc.ibus_busy = ib;
        ifc.exc_valid = v;
        ifc.exc_type  = t;
        ifc.exc_eret  = er;
        ifc.cp0_epc   = epc;

        exp_busy = m_open;
        exp_exc  = m_open && (m_flush == cyc);
        if (!m_open)      exp_stall = v ? 4'h0 : sreq;
        else if (exp_exc) exp_stall = 4'h0;
        else              exp_stall = 4'hF;
        exp_scnt = m_scnt;
        exp_ecnt = (m_accepts > 255) ? 8'hFF : 8'(m_accepts);
        accept   = !m_open && v;

        @(negedge clk);
        #1;
        if (exp_stall != 4'h0) m_scnt = m_scnt + 1'b1;
        if (exp_exc) begin
            m_open  = 1'b0;
            m_flush = -1;
        end else if (m_open && (m_flush < 0) && !ib) begin
            m_flush = cyc + 1;
        end
        if (accept) begin
            m_open  = 1'b1;
            m_flush = ib ? -1 : cyc + 1;
            m_accepts++;
            f.pc   = er ? epc : VEC;
            f.code = t;
            sb_q.push_back(f);
        end
        if (r) begin
            m_open    = 1'b0;
            m_flush   = -1;
            m_scnt    = '0;
            m_accepts = 0;
            sb_q.delete();
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
    endtask

    // Monitor: per-cycle outputs against the model, flush payloads against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",     64'(ifc.stall),     64'(exp_stall));
            check("busy",      64'(ifc.busy),      64'(exp_busy));
            check("stall_cnt", 64'(ifc.stall_cnt), 64'(exp_scnt));
            check("exc_cnt",   64'(ifc.exc_cnt),   64'(exp_ecnt));
            check("exception", 64'(ifc.exception), 64'(exp_exc));
            if (ifc.exception === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL flush_unexpected: got exception=1 new_pc=%0h expected no pending redirect (cycle %0d)",
                             ifc.new_pc, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("new_pc",   64'(ifc.new_pc),   64'(mon_e.pc));
                    check("exc_code", 64'(ifc.exc_code), 64'(mon_e.code));
                end
            end else begin
                check("new_pc_idle", 64'(ifc.new_pc), 64'h0);
            end
        end
    end

    initial begin
        bit         rv;
        bit         rr;
        logic [5:0] rt;

        rst           = 1'b1;
        ifc.stall_req = 4'h0;
        ifc.ibus_busy = 1'b0;
        ifc.exc_valid = 1'b0;
        ifc.exc_type  = 6'h0;
        ifc.exc_eret  = 1'b0;
        ifc.cp0_epc   = 32'h0;

        cycle(1'b1, 4'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        chk_en = 1'b1;

        // Stall passthrough
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        idle(1);
        check("passthrough_cnt", 64'(ifc.stall_cnt), 64'd3);

        // Exception with idle bus, stall request overridden
        cycle(1'b0, 4'b0011, 1'b0, 1'b1, 6'h04, 1'b0, 32'h0);
        idle(2);
        check("first_exc_cnt", 64'(ifc.exc_cnt), 64'd1);

        // Exception with bus busy for 4 cycles
        cycle(1'b0, 4'b0010, 1'b1, 1'b1, 6'h0C, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0, 6'h0, 1'b0, 32'h0);
        idle(3);

        // ERET with an exception type present: EPC wins
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 6'h0D, 1'b1, 32'h8000_1234);
        idle(2);

        // Second events during DRAIN and REDIRECT are ignored
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 6'h08, 1'b0, 32'h1111_0000);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 6'h09, 1'b1, 32'h2222_0000);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 6'h0A, 1'b1, 32'h3333_0000);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 6'h0B, 1'b1, 32'h4444_0000);
        idle(2);

        // Reset in the middle of DRAIN cancels the redirect
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 6'h04, 1'b1, 32'h5555_0000);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 6'h0,  1'b0, 32'h0);
        cycle(1'b1, 4'h0, 1'b1, 1'b0, 6'h0,  1'b0, 32'h0);
        idle(4);
        check("rst_busy",    64'(ifc.busy),      64'd0);
        check("rst_exc_cnt", 64'(ifc.exc_cnt),   64'd0);
        check("rst_scnt",    64'(ifc.stall_cnt), 64'd0);

        // Stall counter wrap: climb to all-ones minus one, then stall twice
        while (m_scnt != {{(CW-1){1'b1}}, 1'b0}) cycle(1'b0, 4'b0001, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        cycle(1'b0, 4'b1000, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        cycle(1'b0, 4'b1000, 1'b0, 1'b0, 6'h0, 1'b0, 32'h0);
        idle(1);
        check("stall_cnt_wrap", 64'(ifc.stall_cnt), 64'd0);

        // Exception counter saturation
        for (int i = 0; i < 280; i++) begin
            cycle(1'b0, 4'(($urandom)), 1'b0, 1'b1, 6'($urandom_range(63, 1)),
                  1'($urandom_range(1)), $urandom);
            idle(1);
        end
        check("exc_cnt_sat", 64'(ifc.exc_cnt), 64'hFF);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rv = ($urandom_range(3) == 0);
            rr = ($urandom_range(299) == 0) && !rv;
            rt = rv ? 6'($urandom_range(63, 1)) : 6'($urandom);
            cycle(rr, 4'($urandom), 1'($urandom_range(1)), rv, rt,
                  1'($urandom_range(1)), $urandom);
        end

        idle(8);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It combines per-stage stall requests into the 4-bit stall vector consumed by the inter-stage registers (bit0 inst, bit1 id, bit2 exe, bit3 data). It also sequences exception and ERET redirection: it waits for any outstanding instruction-bus transaction to drain, then issues a one-cycle pipeline flush with the redirect PC. It sits beside the stage registers and the PC unit, and takes exception information from the mem/CP0 stage.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every non-ERET exception
STALL_CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
stall_req  input  4  stall requests: [0] inst fetch wait, [1] id load-use, [2] exe multi-cycle op, [3] data bus wait
ibus_busy  input  1  instruction-bus transaction outstanding
exc_valid  input  1  mem stage reports exception or ERET this cycle
exc_type  input  6  exception type code; nonzero when exc_valid=1
exc_eret  input  1  qualifies exc_valid as ERET
cp0_epc  input  32  current CP0 EPC value
stall  output  4  stall vector to stage registers
exception  output  1  one-cycle flush pulse to all stage registers and the PC unit
new_pc  output  32  redirect target; valid while exception=1
busy  output  1  controller is not in RUN
stall_cnt  output  STALL_CNT_W  count of cycles with stall!=0
exc_cnt  output  8  count of accepted exceptions and ERETs, saturating

Behaviour:
- Reset, synchronous and active-high: state=RUN, exception=0, new_pc=0, stall_cnt=0, exc_cnt=0. All captured registers clear to 0. Reset in any state, including mid-DRAIN, aborts the pending redirect; no flush is issued afterwards.
- FSM states are RUN, DRAIN and REDIRECT.
- RUN:
  - stall = exc_valid ? 4'b0000 : stall_req (combinational, same cycle).
  - If exc_valid=1, capture the target: cp0_epc if exc_eret=1, else EXC_VECTOR. Capture exc_type.
  - Next state is DRAIN if ibus_busy=1, else REDIRECT.
  - exc_cnt increments on each acceptance and saturates at 8'hFF.
- DRAIN:
  - stall = 4'b1111. exc_valid is ignored (the first event wins).
  - Move to REDIRECT in the cycle after ibus_busy is sampled 0.
- REDIRECT:
  - Registered exception=1 and new_pc=captured target for exactly one cycle; stall=4'b0000.
  - Next state is RUN unconditionally.
  - exc_valid in this cycle is ignored, because the flush kills its source.
- Latency, exception with bus idle: exc_valid at cycle N produces exception=1 at cycle N+1 and exception=0 at N+2.
- Latency, with bus busy: exception=1 comes one cycle after the first cycle ibus_busy=0 is seen in DRAIN.
- busy=1 whenever state is not RUN.
- exception and new_pc are registered outputs. stall is combinational from the state and inputs.
- new_pc returns to 0 when exception=0.
- stall_cnt increments in every cycle where stall!=0, in all states. It wraps from all-ones to 0.
- exc_type is latched only for debug visibility. It does not alter the sequencing.
- Simultaneous events:
  - Any stall_req together with exc_valid in RUN: the exception wins and stall=0 that cycle.
  - ERET together with an exception type: ERET takes the target selection.

Test Plan:
1. Stall passthrough: in RUN, drive stall_req=4'b0100 for 3 cycles with exc_valid=0 -> stall=4'b0100 each cycle, stall_cnt goes 0→3, exception stays 0.
2. Exception, bus idle: exc_valid=1, exc_type=6'h04, ibus_busy=0 at cycle N -> stall=0 at N; exception=1, new_pc=32'hBFC00380 at N+1; exception=0 at N+2; exc_cnt=1.
3. Exception, bus busy: exc_valid=1 with ibus_busy=1, and ibus_busy held high for 4 cycles -> stall=4'b1111 during DRAIN; stall_cnt counts those cycles; exception=1 one cycle after ibus_busy falls.
4. ERET: cp0_epc=32'h8000_1234, exc_valid=1, exc_eret=1 -> new_pc=32'h8000_1234 with a one-cycle exception pulse.
5. Second event ignored: a second exc_valid with cp0_epc changed during DRAIN and during REDIRECT -> new_pc keeps the first target; exc_cnt increments only once.
6. Reset mid-DRAIN: enter DRAIN, assert rst for 1 cycle, then deassert ibus_busy -> no exception pulse; busy=0, stall_cnt=0, exc_cnt=0. Also preload stall_cnt near all-ones and stall 2 cycles -> it wraps to 0.
